// File: rtl/msg_rotate_scanner.sv
// rtl/msg_rotate_scanner.sv - rotating hex message scanner for a 4-digit common-anode display
module msg_rotate_scanner #(
    parameter int                     MSG_LEN   = 16,
    parameter int                     SCAN_DIV  = 16,
    parameter int                     BLANK     = 2,
    parameter int                     ROT_DELAY = 1000,
    parameter logic [4*MSG_LEN-1:0]   INIT_MSG  = 64'h0123456789ABCDEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*MSG_LEN-1:0]   msg_in,
    output logic [3:0]             char,
    output logic [3:0]             an,
    output logic                   frame_start
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int ROT_W  = (ROT_DELAY > 1) ? $clog2(ROT_DELAY) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_V   = SLOT_W'(BLANK);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MSG_LEN - 1);
    localparam logic [PTR_W:0]    LEN_V     = (PTR_W + 1)'(MSG_LEN);
    localparam logic [ROT_W-1:0]  ROT_LAST  = ROT_W'(ROT_DELAY - 1);

    logic [4*MSG_LEN-1:0] msg;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [1:0]           digit;
    logic [PTR_W-1:0]     ptr;
    logic [ROT_W-1:0]     rot_cnt;
    logic                 pending;

    logic                 slot_wrap;
    logic                 rot_wrap;
    logic                 frame_edge;
    logic [PTR_W:0]       idx_sum;
    logic [PTR_W-1:0]     idx;
    logic [PTR_W-1:0]     ptr_next;
    logic [3:0]           an_dec;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign rot_wrap   = (rot_cnt == ROT_LAST);
    assign frame_edge = (digit == 2'd0) && (slot_cnt == '0);
    assign ptr_next   = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);

    // Character index for the current digit, wrapped modulo the message length.
    // ptr + digit is at most MSG_LEN + 2, so a single conditional subtract suffices.
    assign idx_sum = {1'b0, ptr} + (PTR_W + 1)'(digit);
    assign idx     = (idx_sum >= LEN_V) ? PTR_W'(idx_sum - LEN_V) : PTR_W'(idx_sum);

    // Anode decode: all off during the blanking window, else the selected digit low
    always_comb begin
        an_dec = 4'b1111;
        if (slot_cnt >= BLANK_V) begin
            an_dec[3 - digit] = 1'b0;
        end
    end

    // Scan timing: slot counter within a digit, digit counter within a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            digit    <= digit + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
        end
    end

    // Message store, window pointer and rotation request; load overrides rotation
    always_ff @(posedge clk) begin
        if (reset) begin
            msg     <= INIT_MSG;
            ptr     <= '0;
            rot_cnt <= '0;
            pending <= 1'b0;
        end else if (load) begin
            msg     <= msg_in;
            ptr     <= '0;
            rot_cnt <= '0;
            pending <= 1'b0;
        end else begin
            rot_cnt <= rot_wrap ? '0 : rot_cnt + ROT_W'(1);
            if (frame_edge && pending) begin
                ptr <= ptr_next;
            end
            // A new request landing on the consuming clock keeps pending set
            if (rot_wrap) begin
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered outputs: one clock behind the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= 4'b1111;
            char        <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_dec;
            char        <= msg[{idx, 2'b00} +: 4];
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_msg_rotate_scanner.sv
// tb/tb_msg_rotate_scanner.sv - randomized self-checking bench for msg_rotate_scanner
module tb_msg_rotate_scanner;

    localparam int          L    = 16;
    localparam int          SD   = 8;
    localparam int          BL   = 2;
    localparam int          RD   = 100;
    localparam logic [63:0] INIT = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [63:0] msg_in;
    logic [3:0]  char_o;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset, time since last load, window pointer
    int          m_t;
    int          m_age;
    int          m_ptr;
    bit          m_pending;
    logic [63:0] m_msg;
    logic [3:0]  e_an;
    logic [3:0]  e_char;
    logic        e_fs;

    always #5 clk = ~clk;

    msg_rotate_scanner #(
        .MSG_LEN  (L),
        .SCAN_DIV (SD),
        .BLANK    (BL),
        .ROT_DELAY(RD),
        .INIT_MSG (INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .msg_in     (msg_in),
        .char       (char_o),
        .an         (an),
        .frame_start(frame_start)
    );

    // One clock: the model predicts this edge's outputs from its pre-edge state
    task automatic tick();
        int         slot;
        int         dg;
        logic [3:0] oh;
        @(posedge clk);
        if (reset) begin
            m_t = 0; m_age = 0; m_ptr = 0; m_pending = 0; m_msg = INIT;
            e_an = 4'hF; e_char = 4'h0; e_fs = 1'b0;
        end else begin
            slot   = m_t % SD;
            dg     = (m_t / SD) % 4;
            oh     = 4'b1000 >> dg;
            e_an   = (slot < BL) ? 4'hF : ~oh;
            e_char = m_msg[4*((m_ptr + dg) % L) +: 4];
            e_fs   = ((m_t % (4*SD)) == 0);
            if (load) begin
                m_msg = msg_in; m_ptr = 0; m_age = 0; m_pending = 0;
            end else begin
                if ((m_t % (4*SD)) == 0 && m_pending) begin
                    m_ptr = (m_ptr + 1) % L;
                    m_pending = 0;
                end
                if ((m_age % RD) == RD - 1) m_pending = 1;
                m_age++;
            end
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; msg_in = '0;
        repeat (3) begin
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {4'hF, 4'h0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold an=%b char=%h fs=%b need an=1111 char=0 fs=0", an, char_o, frame_start);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({an, char_o, frame_start} !== {4'hF, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first an=%b char=%h fs=%b need an=1111 char=0 fs=1", an, char_o, frame_start);
        end
        for (int c = 2; c <= 70; c++) begin
            tick();
            checks++;
            if (frame_start !== (((c - 1) % 32) == 0)) begin
                errors++;
                $display("FAIL reset_frame_period c=%0d fs=%b need %b", c, frame_start, ((c - 1) % 32) == 0);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_an;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            tick();
            case ((c - 1) / 8)
                0: want_an = 4'b0111;
                1: want_an = 4'b1011;
                2: want_an = 4'b1101;
                default: want_an = 4'b1110;
            endcase
            if (((c - 1) % 8) < 2) want_an = 4'b1111;
            checks++;
            if (an !== want_an || char_o !== 4'((c - 1) / 8)) begin
                errors++;
                $display("FAIL scan c=%0d an=%b char=%h need an=%b char=%h", c, an, char_o, want_an, 4'((c - 1) / 8));
            end
        end
    endtask

    task automatic test_rotation();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                errors++;
                $display("FAIL rotation c=%0d an=%b char=%h fs=%b need an=%b char=%h fs=%b", c, an, char_o, frame_start, e_an, e_char, e_fs);
            end
            if ((c >= 99 && c <= 104) || (c >= 131 && c <= 136)) begin
                checks++;
                if (char_o !== ((c > 128) ? 4'h1 : 4'h0)) begin
                    errors++;
                    $display("FAIL rotation_step c=%0d char=%h need %h", c, char_o, (c > 128) ? 4'h1 : 4'h0);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int          targets [2] = '{14, 0};
        logic [15:0] tabs    [2] = '{16'hEF01, 16'h0123};
        int          n;
        logic [15:0] tab;
        logic [3:0]  want;
        for (int k = 0; k < 2; k++) begin
            tab = tabs[k];
            n = 0;
            do begin
                tick();
                n++;
                checks++;
                if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                    errors++;
                    $display("FAIL wrap_run an=%b char=%h fs=%b need an=%b char=%h fs=%b", an, char_o, frame_start, e_an, e_char, e_fs);
                end
            end while (m_ptr != targets[k] && n < 4000);
            checks++;
            if (n >= 4000) begin
                errors++;
                $display("FAIL wrap_timeout ptr target %0d not reached model ptr=%0d", targets[k], m_ptr);
            end
            for (int j = 1; j < 32; j++) begin
                tick();
                if ((j % 8) >= 2) begin
                    want = tab[15 - 4*(j/8) -: 4];
                    checks++;
                    if (char_o !== want) begin
                        errors++;
                        $display("FAIL wrap_frame ptr=%0d j=%0d char=%h need %h", targets[k], j, char_o, want);
                    end
                end
            end
        end
    endtask

    task automatic test_load_mid();
        int n = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        while (!(m_ptr == 2 && (m_t % 32) == 19) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL load_setup_timeout model ptr=%0d", m_ptr);
        end
        load = 1'b1; msg_in = 64'hFEDCBA9876543210;
        tick();
        load = 1'b0;
        checks++;
        if (char_o !== 4'h4 || an !== 4'b1101) begin
            errors++;
            $display("FAIL load_before an=%b char=%h need an=1101 char=4", an, char_o);
        end
        tick();
        checks++;
        if (char_o !== 4'h2 || an !== 4'b1101) begin
            errors++;
            $display("FAIL load_switch an=%b char=%h need an=1101 char=2", an, char_o);
        end
        for (int c = 0; c < 300; c++) begin
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                errors++;
                $display("FAIL load_after c=%0d an=%b char=%h fs=%b need an=%b char=%h fs=%b", c, an, char_o, frame_start, e_an, e_char, e_fs);
            end
        end
    endtask

    task automatic test_priority();
        int n = 0;
        reset = 1'b1; load = 1'b1; msg_in = {$urandom, $urandom} | 64'h1;
        tick();
        reset = 1'b0; load = 1'b0;
        checks++;
        if ({an, char_o, frame_start} !== {4'hF, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL prio_reset an=%b char=%h fs=%b need an=1111 char=0 fs=0", an, char_o, frame_start);
        end
        for (int c = 1; c <= 64; c++) begin
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                errors++;
                $display("FAIL prio_init c=%0d an=%b char=%h need an=%b char=%h", c, an, char_o, e_an, e_char);
            end
        end
        reset = 1'b1; tick(); reset = 1'b0;
        while (m_age != RD - 1 && n < 500) begin
            tick();
            n++;
        end
        load = 1'b1; msg_in = {$urandom, $urandom};
        tick();
        load = 1'b0;
        for (int c = 0; c < 260; c++) begin
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                errors++;
                $display("FAIL prio_wrap c=%0d an=%b char=%h need an=%b char=%h", c, an, char_o, e_an, e_char);
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            reset  = ($urandom_range(0, 999) == 0);
            load   = ($urandom_range(0, 149) == 0);
            msg_in = {$urandom, $urandom};
            tick();
            checks++;
            if ({an, char_o, frame_start} !== {e_an, e_char, e_fs}) begin
                errors++;
                $display("FAIL random c=%0d an=%b char=%h fs=%b need an=%b char=%h fs=%b", c, an, char_o, frame_start, e_an, e_char, e_fs);
            end
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; msg_in = '0;
        test_reset();
        test_scan();
        test_rotation();
        test_wrap();
        test_load_mid();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
